// File: rtl/crypto_dispatch.sv
// Crypto instruction dispatcher: launches the hash/encrypt/decrypt engine for a decoded
// request, stalls the CPU while it runs and returns the result as a single write pulse.
module crypto_dispatch #(
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 1024,
   localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              H_int,
   input  logic              E_int,
   input  logic              D_int,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic              hash_done,
   input  logic              enc_done,
   input  logic              dec_done,
   input  logic [DATA_W-1:0] hash_res,
   input  logic [DATA_W-1:0] enc_res,
   input  logic [DATA_W-1:0] dec_res,
   output logic              hash_start,
   output logic              enc_start,
   output logic              dec_start,
   output logic [DATA_W-1:0] acc_a,
   output logic [DATA_W-1:0] acc_b,
   output logic              stall,
   output logic              busy,
   output logic [DATA_W-1:0] res_out,
   output logic              res_wr,
   output logic              timeout_err,
   output logic              conflict_err
);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_COMPLETE} state_t;
   typedef enum logic [1:0] {OP_HASH, OP_ENC, OP_DEC} op_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state, nxt;
   op_t               op;
   logic [CNT_W-1:0]  cnt;
   logic              req, multi_req, sel_done, cnt_expired;
   logic [DATA_W-1:0] sel_res;

   assign req         = H_int | E_int | D_int;
   assign multi_req   = (H_int & E_int) | (H_int & D_int) | (E_int & D_int);
   assign cnt_expired = (cnt == CNT_LAST);

   // Only the engine that was launched may complete the operation.
   always_comb begin
      sel_done = 1'b0;
      sel_res  = '0;
      case (op)
         OP_HASH: begin sel_done = hash_done; sel_res = hash_res; end
         OP_ENC:  begin sel_done = enc_done;  sel_res = enc_res;  end
         OP_DEC:  begin sel_done = dec_done;  sel_res = dec_res;  end
         default: begin sel_done = 1'b0;      sel_res = '0;       end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt;
   end

   // COMPLETE never looks at req, so a still-held opcode is not dispatched twice.
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:     if (req) nxt = S_LAUNCH;
         S_LAUNCH:   nxt = S_WAIT;
         S_WAIT:     if (sel_done || cnt_expired) nxt = S_COMPLETE;
         S_COMPLETE: nxt = S_IDLE;
         default:    nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op           <= OP_HASH;
         acc_a        <= '0;
         acc_b        <= '0;
         cnt          <= '0;
         res_out      <= '0;
         res_wr       <= 1'b0;
         hash_start   <= 1'b0;
         enc_start    <= 1'b0;
         dec_start    <= 1'b0;
         timeout_err  <= 1'b0;
         conflict_err <= 1'b0;
      end else begin
         hash_start <= 1'b0;
         enc_start  <= 1'b0;
         dec_start  <= 1'b0;
         res_wr     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req) begin
                  acc_a        <= op_a;
                  acc_b        <= op_b;
                  op           <= H_int ? OP_HASH : (E_int ? OP_ENC : OP_DEC);
                  conflict_err <= multi_req;
                  timeout_err  <= 1'b0;
                  hash_start   <= H_int;
                  enc_start    <= ~H_int & E_int;
                  dec_start    <= ~H_int & ~E_int & D_int;
               end
            end
            S_LAUNCH: cnt <= '0;
            S_WAIT: begin
               cnt <= cnt + CNT_W'(1);
               // A done on the final count still wins over the timeout.
               if (sel_done) begin
                  res_out <= sel_res;
                  res_wr  <= 1'b1;
               end else if (cnt_expired) begin
                  res_out     <= '0;
                  timeout_err <= 1'b1;
                  res_wr      <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy  = (state == S_LAUNCH) || (state == S_WAIT);
   assign stall = rst_n & (((state == S_IDLE) & req) | busy);

endmodule

// File: tb/tb_crypto_dispatch.sv
// Scoreboard bench for crypto_dispatch: randomized requests and engine timing, expected
// write-back and launch records queued by stimulus and checked by independent monitors.
module tb_crypto_dispatch;
   localparam int TB_TIMEOUT = 8;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        H_int = 0, E_int = 0, D_int = 0;
   logic [15:0] op_a = 0, op_b = 0;
   logic        hash_done = 0, enc_done = 0, dec_done = 0;
   logic [15:0] hash_res = 0, enc_res = 0, dec_res = 0;
   logic        hash_start, enc_start, dec_start, stall, busy, res_wr;
   logic        timeout_err, conflict_err;
   logic [15:0] acc_a, acc_b, res_out;

   crypto_dispatch #(.DATA_W(16), .TIMEOUT(TB_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .H_int(H_int), .E_int(E_int), .D_int(D_int),
      .op_a(op_a), .op_b(op_b), .hash_done(hash_done), .enc_done(enc_done),
      .dec_done(dec_done), .hash_res(hash_res), .enc_res(enc_res), .dec_res(dec_res),
      .hash_start(hash_start), .enc_start(enc_start), .dec_start(dec_start),
      .acc_a(acc_a), .acc_b(acc_b), .stall(stall), .busy(busy), .res_out(res_out),
      .res_wr(res_wr), .timeout_err(timeout_err), .conflict_err(conflict_err));

   always #5 clk = ~clk;

   typedef struct {logic [15:0] res; logic tmo; logic conf;} exp_t;
   typedef struct {int op; logic [15:0] a; logic [15:0] b;} st_t;

   exp_t exp_q[$];
   st_t  start_q[$];
   int   checks = 0, errors = 0;
   logic [15:0] last_res = 0;
   logic        last_tmo = 0, last_conf = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Write-back monitor.
   always @(negedge clk) begin
      if (rst_n && res_wr) begin
         exp_t e;
         if (exp_q.size() == 0) begin
            chk("unexpected_res_wr", 32'(res_out), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("res_out", 32'(res_out), 32'(e.res));
            chk("timeout_err", 32'(timeout_err), 32'(e.tmo));
            chk("conflict_err", 32'(conflict_err), 32'(e.conf));
            chk("stall_in_complete", 32'(stall), 32'd0);
            last_res = e.res; last_tmo = e.tmo; last_conf = e.conf;
         end
      end
   end

   // Launch monitor.
   always @(negedge clk) begin
      if (rst_n && (hash_start | enc_start | dec_start)) begin
         st_t s;
         int  got;
         got = hash_start ? 0 : (enc_start ? 1 : 2);
         chk("start_onehot", 32'($countones({hash_start, enc_start, dec_start})), 32'd1);
         if (start_q.size() == 0) begin
            chk("unexpected_start", 32'(got), 32'hFFFF_FFFF);
         end else begin
            s = start_q.pop_front();
            chk("start_engine", 32'(got), 32'(s.op));
            chk("acc_a", 32'(acc_a), 32'(s.a));
            chk("acc_b", 32'(acc_b), 32'(s.b));
            chk("busy_launch", 32'(busy), 32'd1);
         end
      end
   end

   task automatic set_done(input int eng, input logic [15:0] v);
      case (eng)
         0: begin hash_done = 1; hash_res = v; end
         1: begin enc_done = 1; enc_res = v; end
         default: begin dec_done = 1; dec_res = v; end
      endcase
   endtask

   // One request: done arrives dly cycles after the start pulse; dly > TB_TIMEOUT means never.
   task automatic run_txn(input logic h, input logic e, input logic d, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] r, input int dly,
                          input bit stray, input bit lstray);
      int   op, cyc, exp_cyc, nreq;
      bit   tmo, fin;
      exp_t ex;
      st_t  st;
      op   = h ? 0 : (e ? 1 : 2);
      nreq = int'(h) + int'(e) + int'(d);
      tmo  = dly > TB_TIMEOUT;
      ex.res = tmo ? 16'h0 : r; ex.tmo = tmo; ex.conf = nreq > 1;
      st.op = op; st.a = a; st.b = b;
      exp_q.push_back(ex);
      start_q.push_back(st);
      @(negedge clk);
      H_int = h; E_int = e; D_int = d; op_a = a; op_b = b;
      #1 chk("req_stall", 32'(stall), 32'd1);
      cyc = 0; fin = 0;
      while (!fin) begin
         @(negedge clk);
         cyc++;
         hash_done = 0; enc_done = 0; dec_done = 0;
         hash_res = 16'($urandom); enc_res = 16'($urandom); dec_res = 16'($urandom);
         if (cyc == 1) begin op_a = 16'($urandom); op_b = 16'($urandom); end
         if (cyc == 1 && lstray) set_done(op, 16'($urandom));
         if (stray && cyc == 2) set_done((op + 1 + int'($urandom_range(0, 1))) % 3, 16'($urandom));
         if (!tmo && cyc == 1 + dly) set_done(op, r);
         #1;
         if (!stall) fin = 1;
         else if (cyc > 2 * TB_TIMEOUT + 8) begin
            chk("complete_bound", 32'(cyc), 32'hFFFF_FFFF);
            fin = 1;
         end
      end
      exp_cyc = tmo ? TB_TIMEOUT + 2 : dly + 2;
      chk("latency", 32'(cyc), 32'(exp_cyc));
   endtask

   task automatic idle();
      @(negedge clk);
      H_int = 0; E_int = 0; D_int = 0;
      #1;
      chk("idle_stall", 32'(stall), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("hold_res_out", 32'(res_out), 32'(last_res));
      chk("hold_timeout_err", 32'(timeout_err), 32'(last_tmo));
      chk("hold_conflict_err", 32'(conflict_err), 32'(last_conf));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_starts"}, 32'({hash_start, enc_start, dec_start}), 32'd0);
      chk({tag, "_acc"}, {acc_a, acc_b}, 32'd0);
      chk({tag, "_res"}, 32'({res_out, res_wr}), 32'd0);
      chk({tag, "_flags"}, 32'({stall, busy, timeout_err, conflict_err}), 32'd0);
   endtask

   initial begin
      #(400000);
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      logic h, e, d;
      int   v, dly;
      bit   hold;
      #2 chk_all_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1;

      // Hash basic.
      run_txn(1, 0, 0, 16'h1234, 16'h00FF, 16'hBEEF, 2, 0, 0);
      idle();
      // Held encrypt request: second dispatch only from the IDLE cycle.
      run_txn(0, 1, 0, 16'h1111, 16'h2222, 16'hCAFE, 1, 0, 0);
      run_txn(0, 1, 0, 16'h3333, 16'h4444, 16'hF00D, 3, 0, 1);
      idle();
      // Conflict with stray done from another engine.
      run_txn(1, 1, 0, 16'hA5A5, 16'h5A5A, 16'h7777, 4, 1, 0);
      idle();
      // Timeout, then boundary where done lands on the last WAIT cycle.
      run_txn(0, 0, 1, 16'h0F0F, 16'hF0F0, 16'h9999, TB_TIMEOUT + 1, 1, 0);
      idle();
      run_txn(0, 0, 1, 16'h1357, 16'h2468, 16'h8642, TB_TIMEOUT, 0, 0);
      idle();

      // Reset in WAIT with the request still held.
      start_q.push_back('{1, 16'hDEAD, 16'hBEAD});
      @(negedge clk);
      E_int = 1; op_a = 16'hDEAD; op_b = 16'hBEAD;
      repeat (3) @(negedge clk);
      #1 rst_n = 0;
      #1 chk_all_zero("midreset");
      @(negedge clk);
      E_int = 0;
      rst_n = 1;
      last_res = 0; last_tmo = 0; last_conf = 0;
      @(negedge clk);
      enc_done = 1; enc_res = 16'h4321;
      @(negedge clk);
      enc_done = 0;
      repeat (3) @(negedge clk);
      #1 chk_all_zero("late_done");

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         v = int'($urandom_range(1, 7));
         h = v[0]; e = v[1]; d = v[2];
         dly = ($urandom_range(0, 7) == 0) ? TB_TIMEOUT + 1 : int'($urandom_range(1, TB_TIMEOUT));
         hold = ($urandom_range(0, 3) == 0);
         run_txn(h, e, d, 16'($urandom), 16'($urandom), 16'($urandom), dly,
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
         if (!hold) idle();
      end
      idle();
      repeat (3) @(negedge clk);
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      chk("start_q_drained", 32'(start_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/crypto_dispatch.md
Name: crypto_dispatch

Overview:
- Sits directly downstream of the opcode decoder. Consumes its H_int / E_int / D_int request lines and launches the hash, encrypt or decrypt engine.
- Stalls the CPU while the selected engine runs, then returns the engine result to the register file as a single write pulse.
- Adds timeout protection and conflict detection around a 4-state FSM.

Parameters:
- DATA_W, 16, width of operands and result.
- TIMEOUT, 1024, maximum WAIT cycles before abort; legal range 2..65535.
- CNT_W, $clog2(TIMEOUT+1), timeout counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- H_int  in  1  hash request from decoder (level; held while opcode held).
- E_int  in  1  encrypt request from decoder.
- D_int  in  1  decrypt request from decoder.
- op_a  in  DATA_W  operand A (source register read data).
- op_b  in  DATA_W  operand B (key / second source).
- hash_done  in  1  hash engine completion pulse.
- enc_done  in  1  encrypt engine completion pulse.
- dec_done  in  1  decrypt engine completion pulse.
- hash_res  in  DATA_W  hash engine result, valid with hash_done.
- enc_res  in  DATA_W  encrypt engine result, valid with enc_done.
- dec_res  in  DATA_W  decrypt engine result, valid with dec_done.
- hash_start  out  1  one-cycle launch pulse to hash engine.
- enc_start  out  1  one-cycle launch pulse to encrypt engine.
- dec_start  out  1  one-cycle launch pulse to decrypt engine.
- acc_a  out  DATA_W  latched operand A to engines.
- acc_b  out  DATA_W  latched operand B to engines.
- stall  out  1  freeze PC / pipeline.
- busy  out  1  high in LAUNCH or WAIT.
- res_out  out  DATA_W  result to register file write data.
- res_wr  out  1  one-cycle register file write strobe.
- timeout_err  out  1  last operation timed out.
- conflict_err  out  1  last request had more than one of H/E/D high.

Behaviour:
- Reset (async, rst_n low): state=IDLE. All outputs 0, including acc_a, acc_b, res_out, both error flags and the counter. Takes effect immediately mid-operation.
  - No res_wr is produced for an interrupted operation.
  - Any later done from the interrupted engine arrives in IDLE and is ignored.
- req = H_int | E_int | D_int.
- States:
  - IDLE → LAUNCH when req=1 at the clock edge. At that edge:
    - Latch op_a→acc_a and op_b→acc_b.
    - Latch selected op, priority H > E > D.
    - conflict_err <= (popcount(H,E,D) > 1).
    - timeout_err <= 0.
  - LAUNCH (1 cycle): exactly one of hash_start / enc_start / dec_start = 1, per the latched op. Counter <= 0. Done inputs are ignored here. Always → WAIT.
  - WAIT: counter increments each cycle.
    - Done of the selected engine → COMPLETE; res_out <= that engine's result.
    - Done from a non-selected engine is ignored.
    - Counter == TIMEOUT-1 with no done → COMPLETE; res_out <= 0; timeout_err <= 1. A done in that same cycle wins: normal completion, no timeout.
  - COMPLETE (1 cycle): res_wr = 1 and stall = 0, so the CPU advances at this edge. req is ignored in this state, which prevents re-dispatching the still-held opcode. Always → IDLE.
- stall = (IDLE & req) | LAUNCH | WAIT. This is the only combinational output, so the request cycle freezes the PC with no slip.
- busy = LAUNCH | WAIT (registered state decode).
- *_start, res_wr, res_out, acc_a, acc_b are all registered.
- res_out holds its value until the next COMPLETE.
- Error flags hold until the next accepted request.
- Latency: with the request in cycle 0, start is in cycle 1, the earliest done in cycle 2, and res_wr in cycle 3. Minimum total stall is 3 cycles.
- Back-to-back: a new request is accepted in IDLE the cycle after COMPLETE.

Test Plan:
- Hash basic: H_int=1, op_a=16'h1234, op_b=16'h00FF; hash_done with hash_res=16'hBEEF 2 cycles after start → hash_start pulses once in cycle 1, stall high cycles 0–3 except low in COMPLETE, res_wr=1 with res_out=16'hBEEF, errors 0.
- Held request: E_int held high through COMPLETE and one cycle into IDLE → exactly one enc_start, then a second dispatch only from the IDLE cycle; two res_wr total.
- Conflict: H_int=E_int=1 → hash_start only, conflict_err=1. Stray enc_done during WAIT ignored; completion only on hash_done.
- Timeout: TIMEOUT=8, D_int, no dec_done → COMPLETE after 8 WAIT cycles, res_out=0, timeout_err=1, res_wr=1. Next request clears timeout_err.
- Reset mid-WAIT: assert rst_n=0 in WAIT → all outputs 0 immediately. A late enc_done after release produces no res_wr; state remains IDLE.
